// File: rtl/ether_pkg.sv
// ether_pkg: shared Ethernet constants, TX state encoding and a byte-wide
// CRC-32 step function used by the ARP request generator and RX checker.
package ether_pkg;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [15:0] ETYPE_ARP     = 16'h0806;
  localparam logic [15:0] ETYPE_VLAN    = 16'h8100;
  localparam logic [15:0] ETYPE_IP      = 16'h0800;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  localparam int          ETH_MIN_FRAME = 64;
  localparam int          ARP_LEN       = 28;
  localparam int          FCS_LEN       = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_HDR, S_ARP, S_PAD, S_FCS, S_IFG
  } tx_state_t;

  // One byte of reflected CRC-32, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] din);
    logic [31:0] c;
    c = crc ^ {24'h0, din};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/ether_crc32_d8.sv
// ether_crc32_d8: 8-bit-per-cycle CRC-32 register (raw, not inverted).
// Ports: clk, rst (sync, high) / init (load all-ones, wins over en) /
//        en (fold din into crc) / din [7:0] / crc [31:0] current register.
module ether_crc32_d8
  import ether_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || init) crc <= '1;
    else if (en)     crc <= crc32_byte(crc, din);
  end

endmodule

// File: rtl/ether_arp_request_tx.sv
// ether_arp_request_tx: ARP request frame generator on a byte-wide GMII TX
// interface. Emits preamble/SFD, broadcast header, ARP request, zero pad and
// CRC-32 FCS, then holds an inter-frame gap.
// Ports: clk, rst (sync, high); start / target_ip [31:0] request inputs;
//        busy, done status; en, er, data [7:0] GMII TX outputs.
// Build option: ETHER_ARP_TX_VLAN_EN inserts an 802.1Q tag (8100, VLAN_TCI)
// after the source MAC; the pad shrinks so total length is unchanged.
module ether_arp_request_tx
  import ether_pkg::*;
#(
  parameter logic [47:0] SRC_MAC      = 48'h00301ba0a48e,
  parameter logic [31:0] SRC_IP       = 32'h0a00150a,
  parameter int          PREAMBLE_LEN = 7,
  parameter int          IFG_CYCLES   = 12,
  parameter int          AUTO_PERIOD  = 0,
  parameter logic [15:0] VLAN_TCI     = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] target_ip,
  output logic        busy,
  output logic        done,
  output logic        en,
  output logic        er,
  output logic [7:0]  data
);

  // Header bytes in transmit order, tag always present in the table; the
  // untagged build drops bytes 12..15.
  localparam logic [0:17][7:0] HDR_TAGGED = {48'hFFFF_FFFF_FFFF, SRC_MAC,
                                             ETYPE_VLAN, VLAN_TCI, ETYPE_ARP};
`ifdef ETHER_ARP_TX_VLAN_EN
  localparam int               HDR_LEN = 18;
  localparam logic [0:17][7:0] HDR_B   = HDR_TAGGED;
`else
  localparam int               HDR_LEN = 14;
  localparam logic [0:17][7:0] HDR_B   = {HDR_TAGGED[0:11], HDR_TAGGED[16:17], 32'h0};
`endif
  localparam int PAD_LEN = ETH_MIN_FRAME - FCS_LEN - HDR_LEN - ARP_LEN;

  tx_state_t        state, state_n;
  logic [7:0]       cnt, cnt_n, last_cnt, byte_n;
  logic [31:0]      tip, crc;
  logic             accept, timer_fire, crc_init, crc_en;
  logic [0:27][7:0] arp_b;
  logic [3:0][7:0]  fcs_b;

  assign accept = (state == S_IDLE) && (start || timer_fire);
  assign arp_b  = {16'h0001, ETYPE_IP, 8'd6, 8'd4, 16'h0001, SRC_MAC, SRC_IP, 48'h0, tip};
  assign fcs_b  = ~crc;

  always_comb begin
    last_cnt = 8'd0;
    case (state)
      S_PRE:   last_cnt = 8'(PREAMBLE_LEN - 1);
      S_HDR:   last_cnt = 8'(HDR_LEN - 1);
      S_ARP:   last_cnt = 8'(ARP_LEN - 1);
      S_PAD:   last_cnt = 8'(PAD_LEN - 1);
      S_FCS:   last_cnt = 8'(FCS_LEN - 1);
      S_IFG:   last_cnt = 8'(IFG_CYCLES - 1);
      default: last_cnt = 8'd0;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 8'd1;
    if (state == S_IDLE) begin
      cnt_n = 8'd0;
      if (accept) state_n = S_PRE;
    end else if (cnt == last_cnt) begin
      cnt_n = 8'd0;
      case (state)
        S_PRE:   state_n = S_SFD;
        S_SFD:   state_n = S_HDR;
        S_HDR:   state_n = S_ARP;
        S_ARP:   state_n = S_PAD;
        S_PAD:   state_n = S_FCS;
        S_FCS:   state_n = S_IFG;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state, so the byte mux looks at
  // state_n/cnt_n. The CRC register has absorbed the last pad byte by the
  // time state_n first reaches FCS.
  always_comb begin
    byte_n = 8'h00;
    case (state_n)
      S_PRE:   byte_n = ETH_PREAMBLE;
      S_SFD:   byte_n = ETH_SFD;
      S_HDR:   byte_n = HDR_B[cnt_n[4:0]];
      S_ARP:   byte_n = arp_b[cnt_n[4:0]];
      S_FCS:   byte_n = fcs_b[cnt_n[1:0]];
      default: byte_n = 8'h00;
    endcase
  end

  assign crc_init = (state_n == S_PRE);
  assign crc_en   = (state_n == S_HDR) || (state_n == S_ARP) || (state_n == S_PAD);

  ether_crc32_d8 u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (crc_init),
    .en   (crc_en),
    .din  (byte_n),
    .crc  (crc)
  );

  // Auto-repeat: counts consecutive IDLE cycles, fires on the Nth.
  if (AUTO_PERIOD > 0) begin : g_auto
    logic [31:0] timer;
    always_ff @(posedge clk) begin
      if (rst)                                          timer <= '0;
      else if ((state == S_IDLE) && (state_n == S_IDLE)) timer <= timer + 32'd1;
      else                                              timer <= '0;
    end
    assign timer_fire = (timer == 32'(AUTO_PERIOD - 1));
  end else begin : g_trig
    assign timer_fire = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
      tip   <= '0;
      en    <= 1'b0;
      data  <= 8'h00;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) tip <= target_ip;
      en    <= (state_n != S_IDLE) && (state_n != S_IFG);
      data  <= byte_n;
      busy  <= (state_n != S_IDLE);
      done  <= (state == S_FCS) && (state_n == S_IFG);
    end
  end

  assign er = 1'b0;

endmodule

// File: tb/tb_ether_arp_request_tx.sv
module tb_ether_arp_request_tx;

  localparam logic [47:0] MAC    = 48'h00301ba0a48e;
  localparam logic [31:0] SIP    = 32'h0a00150a;
  localparam int          FLEN   = 72;   // en-high cycles per frame
  localparam int          GAP    = 85;   // accept-to-next-accept minimum
  localparam int          AUTO_P = 100;
`ifdef ETHER_ARP_TX_VLAN_EN
  localparam int          TPA_OFF = 50;
`else
  localparam int          TPA_OFF = 46;
`endif

  logic        clk = 1'b0;
  logic        rst, start, rst_a, start_a;
  logic [31:0] target_ip, target_ip_a;
  logic        busy, done, en, er, busy_a, done_a, en_a, er_a;
  logic [7:0]  data, data_a;

  always #4 clk = ~clk;

  ether_arp_request_tx dut (
    .clk(clk), .rst(rst), .start(start), .target_ip(target_ip),
    .busy(busy), .done(done), .en(en), .er(er), .data(data)
  );

  ether_arp_request_tx #(.AUTO_PERIOD(AUTO_P)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .target_ip(target_ip_a),
    .busy(busy_a), .done(done_a), .en(en_a), .er(er_a), .data(data_a)
  );

  int   cyc = 0;
  logic rst_s = 1'b1, rst_as = 1'b1;
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rst_s  <= rst;
    rst_as <= rst_a;
  end

  int n_chk = 0, n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 25) $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [31:0] acc; logic [31:0] ip; } exp_t;
  exp_t       sbq[$];
  int         aq[$];
  logic [7:0] mq[$];
  logic [7:0] cur_b [FLEN];

  task automatic push_be(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) mq.push_back(v[8*i +: 8]);
  endtask

  function automatic logic [31:0] crc_sw(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Whole frame as it should appear on the wire, preamble through FCS.
  task automatic build_frame(input logic [31:0] tip);
    logic [31:0] c;
    mq = {};
    repeat (7) mq.push_back(8'h55);
    mq.push_back(8'hD5);
    push_be(64'hFFFF_FFFF_FFFF, 6);
    push_be({16'h0, MAC}, 6);
`ifdef ETHER_ARP_TX_VLAN_EN
    push_be(64'h8100_0001, 4);
`endif
    push_be(64'h0806, 2);
    push_be(64'h0001_0800_0604_0001, 8);
    push_be({16'h0, MAC}, 6);
    push_be({32'h0, SIP}, 4);
    push_be(64'h0, 6);
    push_be({32'h0, tip}, 4);
    while (mq.size() < 68) mq.push_back(8'h00);
    c = '1;
    for (int i = 8; i < 68; i++) c = crc_sw(c, mq[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) mq.push_back(c[8*i +: 8]);
    for (int i = 0; i < FLEN; i++) cur_b[i] = mq[i];
  endtask

  // ---------------- main monitor / scoreboard ----------------
  initial begin : mon
    exp_t        cur;
    bit          have;
    int          off, fno;
    logic        e_en, e_done, e_busy;
    logic [7:0]  e_dat;
    logic [7:0]  cap [FLEN];
    logic [31:0] c;
    have = 0; fno = 0; cur = '0;
    forever begin
      @(negedge clk);
      if (rst_s) begin
        have = 0;
        check("rst_en", 32'(en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_data", 32'(data), 0);
      end else begin
        if (!have && sbq.size() > 0 && int'(sbq[0].acc) + 1 == cyc) begin
          cur  = sbq.pop_front();
          have = 1;
          build_frame(cur.ip);
        end
        off    = have ? cyc - int'(cur.acc) : 0;
        e_en   = have && off >= 1 && off <= FLEN;
        e_dat  = e_en ? cur_b[off-1] : 8'h00;
        e_done = have && off == FLEN + 1;
        e_busy = have && off >= 1 && off <= FLEN + 12;
        check("en", 32'(en), 32'(e_en));
        check("data", 32'(data), 32'(e_dat));
        check("done", 32'(done), 32'(e_done));
        check("busy", 32'(busy), 32'(e_busy));
        check("er", 32'(er), 0);
        if (e_en) cap[off-1] = data;
        if (have && off == FLEN) begin
          c = '1;
          for (int i = 8; i < FLEN; i++) c = crc_sw(c, cap[i]);
          check("fcs_residue", c, 32'hDEBB20E3);
          if (fno == 0) begin
            check("f0_pre", {cap[0], cap[3], cap[6], cap[7]}, 32'h555555D5);
            check("f0_dst_a", {cap[8], cap[9], cap[10], cap[11]}, 32'hFFFFFFFF);
            check("f0_dst_b", {16'h0, cap[12], cap[13]}, 32'h0000FFFF);
            check("f0_tpa", {cap[TPA_OFF], cap[TPA_OFF+1], cap[TPA_OFF+2], cap[TPA_OFF+3]}, 32'h0a001563);
          end
          fno++;
        end
        if (have && off == FLEN + 12) have = 0;
      end
    end
  end

  // ---------------- main driver ----------------
  int next_free = 0;

  task automatic step(input logic r, input logic s, input logic [31:0] ip);
    exp_t e;
    rst = r; start = s; target_ip = ip;
    if (r) next_free = cyc + 1;
    else if (s && cyc >= next_free) begin
      e.acc = 32'(cyc); e.ip = ip;
      sbq.push_back(e);
      next_free = cyc + GAP;
    end
    @(posedge clk); #1;
  endtask

  bit auto_done = 0;

  initial begin : main_drv
    int a;
    rst = 1'b1; start = 1'b0; target_ip = '0;
    repeat (3) step(1'b1, 1'b0, 32'h0);
    check("reset_busy", 32'(busy), 0);
    check("reset_en", 32'(en), 0);
    check("reset_done", 32'(done), 0);
    check("reset_data", 32'(data), 0);
    // single triggered frame
    repeat (2) step(1'b0, 1'b0, $urandom);
    step(1'b0, 1'b1, 32'h0a001563);
    repeat (95) step(1'b0, 1'b0, $urandom);
    // random starts, target_ip churning every cycle, rare resets
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 399) == 0, $urandom_range(0, 7) == 0, $urandom);
    // start held high: back-to-back frames at minimum spacing
    repeat (300) step(1'b0, 1'b1, $urandom);
    // reset in the middle of a frame, then restart
    while (cyc < next_free) step(1'b0, 1'b0, $urandom);
    a = cyc;
    step(1'b0, 1'b1, $urandom);
    while (cyc < a + 31) step(1'b0, 1'b0, $urandom);
    step(1'b1, 1'b0, $urandom);
    repeat (2) step(1'b0, 1'b0, $urandom);
    step(1'b0, 1'b1, $urandom);
    repeat (100) step(1'b0, 1'b0, $urandom);
    for (int i = 0; i < 3000 && !auto_done; i++) step(1'b0, 1'b0, 32'h0);
    check("auto_finished", 32'(auto_done), 1);
    check("auto_pending", 32'(aq.size()), 0);
    check("sb_pending", 32'(sbq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // ---------------- auto-repeat instance ----------------
  initial begin : auto_drv
    int r;
    rst_a = 1'b1; start_a = 1'b0; target_ip_a = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    r = cyc;
    // first fire after AUTO_P idle cycles, then frame + gap + AUTO_P
    for (int i = 0; i < 4; i++) aq.push_back(r + AUTO_P + i * (FLEN + 12 + AUTO_P));
    while (cyc < r + AUTO_P - 1 + (FLEN + 12 + AUTO_P)) begin
      target_ip_a = $urandom;
      @(posedge clk); #1;
    end
    // start lands on the same cycle as the timer, then again while busy
    start_a = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    start_a = 1'b0;
    while (cyc < r + AUTO_P + 3 * (FLEN + 12 + AUTO_P) + FLEN + 8) begin
      @(posedge clk); #1;
    end
    rst_a = 1'b1;
    auto_done = 1;
  end

  initial begin : auto_mon
    logic pe;
    int   len;
    pe = 1'b0; len = 0;
    forever begin
      @(negedge clk);
      if (!rst_as) begin
        check("auto_er", 32'(er_a), 0);
        if (en_a && !pe) begin
          if (aq.size() == 0) check("auto_extra_frame", 32'(cyc), 0);
          else                check("auto_start_cyc", 32'(cyc), 32'(aq.pop_front()));
          check("auto_busy", 32'(busy_a), 1);
          check("auto_first_byte", 32'(data_a), 32'h55);
          len = 0;
        end
        if (en_a) len++;
        if (!en_a && pe) begin
          check("auto_len", 32'(len), 32'(FLEN));
          check("auto_done", 32'(done_a), 1);
        end
      end
      pe = en_a && !rst_as;
    end
  end

endmodule
